irq_rr_scheduler: RTL

Round-robin scheduler that shares a single downstream service port between N edge-triggered request sources. It latches request events into a pending register, filters them through a software-writable mask, and selects one eligible source per grant using a rotating-priority encoder. It presents the chosen source index over a valid/ack handshake and sits between the raw request lines and the consumer that services one index at a time.

---
 rtl/irq_rr_scheduler_if.sv | 12 +
 rtl/irq_rr_scheduler.sv | 99 +++++++++
 2 files changed

// File: rtl/irq_rr_scheduler_if.sv
// Service-port handshake between the round-robin scheduler and its consumer.
// The scheduler offers an index on valid/id; the consumer takes it with ack.
interface irq_rr_scheduler_if #(
  parameter int W = 3
);
  logic         valid;
  logic [W-1:0] id;
  logic         ack;

  modport master (output valid, output id, input ack);
  modport slave  (input valid, input id, output ack);
endinterface

// File: rtl/irq_rr_scheduler.sv
// Round-robin scheduler: latches request edges into pending, filters by mask,
// and offers one eligible source index at a time over a valid/ack port.
//
// state | meaning
// IDLE  | no offer outstanding; arbitrate among pending & ~mask
// OFFER | valid=1, id held until the consumer acks
module irq_rr_scheduler #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 mask_we,
  input  logic [N-1:0]         mask_wdata,
  output logic [N-1:0]         mask,
  output logic [N-1:0]         pending,
  output logic                 lost,
  irq_rr_scheduler_if.master   svc
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t       state;
  logic [W-1:0] ptr;
  logic [N-1:0] req_d;
  logic [N-1:0] rise;
  logic [N-1:0] clr;
  logic [N-1:0] eligible;
  logic [N-1:0] one_hot0;
  logic         found;
  logic [W-1:0] win;

  assign one_hot0 = {{(N-1){1'b0}}, 1'b1};
  assign rise     = req & ~req_d;
  assign clr      = (state == OFFER && svc.ack) ? (one_hot0 << svc.id) : '0;
  assign eligible = pending & ~mask;

  // Search starts at ptr; W-bit addition wraps naturally because N is a power of two.
  always_comb begin
    logic [W-1:0] idx;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = ptr + W'(i);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_d   <= '0;
      pending <= '0;
      mask    <= '1;
      lost    <= 1'b0;
    end else begin
      req_d   <= req;
      pending <= (pending & ~clr) | rise;
      lost    <= |(rise & pending & ~clr);
      if (mask_we)
        mask <= mask_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      svc.valid <= 1'b0;
      svc.id    <= '0;
      ptr       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            svc.id    <= win;
            svc.valid <= 1'b1;
            state     <= OFFER;
          end
        end
        OFFER: begin
          if (svc.ack) begin
            svc.valid <= 1'b0;
            ptr       <= svc.id + 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          svc.valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
